// File: rtl/qrd_pkg.sv
// Shared constants and state type for the QRD input/output scheduler.
package qrd_pkg;

  localparam int QRD_W         = 14;
  localparam int QRD_ONE       = 1024;
  localparam int QRD_N         = 4;
  localparam int QRD_AUG_COLS  = 8;
  localparam int QRD_LAST_STEP = 15;

  // Core output windows: row k emits R at s-k in [5,9) and QH at s-k in [9,13).
  localparam int QRD_R_START  = 5;
  localparam int QRD_QH_START = 9;
  localparam int QRD_WIN_END  = 13;

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StDrain} qrd_state_e;

endpackage

// File: rtl/qrd_result_buf.sv
// Result storage: one 8-entry bank per core row (R columns 0..3, QH columns 4..7).
module qrd_result_buf
  import qrd_pkg::*;
#(
  parameter int W = QRD_W
) (
  input  logic                      clk,
  input  logic [QRD_N-1:0]          wr_en,
  input  logic [QRD_N-1:0][2:0]     wr_idx,
  input  logic [QRD_N-1:0][W-1:0]   wr_r,
  input  logic [QRD_N-1:0][W-1:0]   wr_i,
  input  logic [1:0]                rd_row,
  input  logic [2:0]                rd_idx,
  output logic [W-1:0]              rd_r,
  output logic [W-1:0]              rd_i
);

  logic [W-1:0] mem_r [QRD_N][QRD_AUG_COLS];
  logic [W-1:0] mem_i [QRD_N][QRD_AUG_COLS];

  always_ff @(posedge clk) begin
    for (int k = 0; k < QRD_N; k++) begin
      if (wr_en[k]) begin
        mem_r[k][wr_idx[k]] <= wr_r[k];
        mem_i[k][wr_idx[k]] <= wr_i[k];
      end
    end
  end

  assign rd_r = mem_r[rd_row][rd_idx];
  assign rd_i = mem_i[rd_row][rd_idx];

endmodule

// File: rtl/qrd_scheduler.sv
// Loads a 4x4 complex H, drives the skewed augmented rows into a QRD core,
// collects R and QH from the core and streams them out.
module qrd_scheduler
  import qrd_pkg::*;
#(
  parameter int W   = QRD_W,
  parameter int ONE = QRD_ONE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_r,
  input  logic [W-1:0] s_i,
  output logic [W-1:0] row_in_1_r,
  output logic [W-1:0] row_in_1_i,
  output logic [W-1:0] row_in_2_r,
  output logic [W-1:0] row_in_2_i,
  output logic [W-1:0] row_in_3_r,
  output logic [W-1:0] row_in_3_i,
  output logic [W-1:0] row_in_4_r,
  output logic [W-1:0] row_in_4_i,
  output logic         row_in_1_f,
  output logic         row_in_2_f,
  output logic         row_in_3_f,
  input  logic         qrd_in_ready,
  input  logic         qrd_out_valid,
  input  logic [W-1:0] row_out_1_r,
  input  logic [W-1:0] row_out_1_i,
  input  logic [W-1:0] row_out_2_r,
  input  logic [W-1:0] row_out_2_i,
  input  logic [W-1:0] row_out_3_r,
  input  logic [W-1:0] row_out_3_i,
  input  logic [W-1:0] row_out_4_r,
  input  logic [W-1:0] row_out_4_i,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_r,
  output logic [W-1:0] m_i,
  output logic         m_sel,
  output logic         m_last,
  output logic         busy
);

  qrd_state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] s_q, s_d;
  logic [4:0] ptr_q, ptr_d;
  logic       s_ready_q, s_ready_d;
  logic       accept;

  logic [QRD_N-1:0][W-1:0] drv_r_q, drv_r_d, drv_i_q, drv_i_d;
  logic [2:0]              drv_f_q, drv_f_d;
  logic [4:0]              drv_col;

  logic         m_valid_q, m_valid_d, m_sel_q, m_sel_d, m_last_q, m_last_d;
  logic [W-1:0] m_r_q, m_r_d, m_i_q, m_i_d;

  logic [W-1:0] h_r [QRD_N][QRD_N];
  logic [W-1:0] h_i [QRD_N][QRD_N];

  logic [QRD_N-1:0]        wr_en;
  logic [QRD_N-1:0][2:0]   wr_idx;
  logic [QRD_N-1:0][W-1:0] row_out_r, row_out_i;
  logic [4:0]              cap_rel;
  logic [1:0]              rd_row;
  logic [2:0]              rd_idx;
  logic [W-1:0]            rd_r, rd_i;

  assign accept = s_valid && s_ready_q;

  assign row_out_r = {row_out_4_r, row_out_3_r, row_out_2_r, row_out_1_r};
  assign row_out_i = {row_out_4_i, row_out_3_i, row_out_2_i, row_out_1_i};

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    s_d       = s_q;
    ptr_d     = ptr_q;
    m_valid_d = m_valid_q;
    m_r_d     = m_r_q;
    m_i_d     = m_i_q;
    m_sel_d   = m_sel_q;
    m_last_d  = m_last_q;
    unique case (state_q)
      StIdle, StLoad: begin
        if (state_q == StIdle && s_valid) state_d = StLoad;
        if (accept) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d = StRun;
            s_d     = '0;
          end
        end
      end
      StRun: begin
        // The final capture ends the run even if the core is stalling its input.
        if (qrd_out_valid && s_q == 4'(QRD_LAST_STEP)) begin
          state_d = StDrain;
          s_d     = '0;
          ptr_d   = '0;
        end else if (qrd_in_ready) begin
          s_d = s_q + 4'd1;
        end
      end
      StDrain: begin
        if (m_valid_q && m_ready && m_last_q) begin
          state_d   = StIdle;
          m_valid_d = 1'b0;
          m_sel_d   = 1'b0;
          m_last_d  = 1'b0;
        end else if (!m_valid_q || m_ready) begin
          m_valid_d = 1'b1;
          m_r_d     = rd_r;
          m_i_d     = rd_i;
          m_sel_d   = ptr_q[4];
          m_last_d  = &ptr_q;
          ptr_d     = ptr_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign s_ready_d = (state_d == StIdle) || (state_d == StLoad);

  // Drive registers follow the next step, so a stall leaves them unchanged.
  always_comb begin
    drv_r_d = '0;
    drv_i_d = '0;
    drv_f_d = '0;
    drv_col = '0;
    if (state_d == StRun) begin
      for (int k = 0; k < QRD_N; k++) begin
        drv_col = {1'b0, s_d} - 5'(k);
        if (drv_col < 5'(QRD_AUG_COLS)) begin
          if (!drv_col[2]) begin
            drv_r_d[k] = h_r[k][drv_col[1:0]];
            drv_i_d[k] = h_i[k][drv_col[1:0]];
          end else if (drv_col[1:0] == 2'(k)) begin
            drv_r_d[k] = W'(ONE);
          end
        end
      end
      drv_f_d = {s_d == 4'd4, s_d == 4'd2, s_d == 4'd0};
    end
  end

  always_comb begin
    wr_en   = '0;
    wr_idx  = '0;
    cap_rel = '0;
    for (int k = 0; k < QRD_N; k++) begin
      cap_rel   = {1'b0, s_q} - 5'(k) - 5'(QRD_R_START);
      wr_en[k]  = (state_q == StRun) && qrd_out_valid &&
                  (cap_rel < 5'(QRD_WIN_END - QRD_R_START));
      wr_idx[k] = cap_rel[2:0];
    end
  end

  assign rd_row = ptr_q[3:2];
  assign rd_idx = ptr_q[4] ? 3'(QRD_QH_START - QRD_R_START) + {1'b0, ptr_q[1:0]}
                           : {1'b0, ptr_q[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      s_q       <= '0;
      ptr_q     <= '0;
      s_ready_q <= 1'b0;
      drv_r_q   <= '0;
      drv_i_q   <= '0;
      drv_f_q   <= '0;
      m_valid_q <= 1'b0;
      m_r_q     <= '0;
      m_i_q     <= '0;
      m_sel_q   <= 1'b0;
      m_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      s_q       <= s_d;
      ptr_q     <= ptr_d;
      s_ready_q <= s_ready_d;
      drv_r_q   <= drv_r_d;
      drv_i_q   <= drv_i_d;
      drv_f_q   <= drv_f_d;
      m_valid_q <= m_valid_d;
      m_r_q     <= m_r_d;
      m_i_q     <= m_i_d;
      m_sel_q   <= m_sel_d;
      m_last_q  <= m_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      h_r[idx_q[3:2]][idx_q[1:0]] <= s_r;
      h_i[idx_q[3:2]][idx_q[1:0]] <= s_i;
    end
  end

  qrd_result_buf #(
    .W(W)
  ) u_result_buf (
    .clk   (clk),
    .wr_en (wr_en),
    .wr_idx(wr_idx),
    .wr_r  (row_out_r),
    .wr_i  (row_out_i),
    .rd_row(rd_row),
    .rd_idx(rd_idx),
    .rd_r  (rd_r),
    .rd_i  (rd_i)
  );

  assign s_ready    = s_ready_q;
  assign busy       = (state_q != StIdle);
  assign row_in_1_r = drv_r_q[0];
  assign row_in_1_i = drv_i_q[0];
  assign row_in_2_r = drv_r_q[1];
  assign row_in_2_i = drv_i_q[1];
  assign row_in_3_r = drv_r_q[2];
  assign row_in_3_i = drv_i_q[2];
  assign row_in_4_r = drv_r_q[3];
  assign row_in_4_i = drv_i_q[3];
  assign row_in_1_f = drv_f_q[0];
  assign row_in_2_f = drv_f_q[1];
  assign row_in_3_f = drv_f_q[2];
  assign m_valid    = m_valid_q;
  assign m_r        = m_r_q;
  assign m_i        = m_i_q;
  assign m_sel      = m_sel_q;
  assign m_last     = m_last_q;

endmodule

// File: tb/tb_qrd_scheduler.sv
// Bench for qrd_scheduler: table-driven identity run plus randomized sessions
// against a matrix-level reference model of load, skew, capture and drain.
module tb_qrd_scheduler;

  localparam int W   = 14;
  localparam int ONE = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_r = '0, s_i = '0;
  logic [3:0][W-1:0] rin_r, rin_i;
  logic [2:0]        rin_f;
  logic         qrd_in_ready = 1'b0, qrd_out_valid = 1'b0;
  logic [3:0][W-1:0] rout_r = '0, rout_i = '0;
  logic         m_valid, m_ready = 1'b0, m_sel, m_last, busy;
  logic [W-1:0] m_r, m_i;

  int nvec = 0;
  int nbad = 0;

  logic [W-1:0] h_r [4][4], h_i [4][4];
  logic [W-1:0] rr [4][4], ri [4][4], qr [4][4], qi [4][4];

  typedef struct {
    bit         rdy;
    int         r1, r2, r3, r4;
    logic [2:0] f;
  } vec_t;
  localparam int NV = 14;
  vec_t tbl [NV];

  always #5 clk = ~clk;

  qrd_scheduler #(.W(W), .ONE(ONE)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_i(s_i),
    .row_in_1_r(rin_r[0]), .row_in_1_i(rin_i[0]),
    .row_in_2_r(rin_r[1]), .row_in_2_i(rin_i[1]),
    .row_in_3_r(rin_r[2]), .row_in_3_i(rin_i[2]),
    .row_in_4_r(rin_r[3]), .row_in_4_i(rin_i[3]),
    .row_in_1_f(rin_f[0]), .row_in_2_f(rin_f[1]), .row_in_3_f(rin_f[2]),
    .qrd_in_ready(qrd_in_ready), .qrd_out_valid(qrd_out_valid),
    .row_out_1_r(rout_r[0]), .row_out_1_i(rout_i[0]),
    .row_out_2_r(rout_r[1]), .row_out_2_i(rout_i[1]),
    .row_out_3_r(rout_r[2]), .row_out_3_i(rout_i[2]),
    .row_out_4_r(rout_r[3]), .row_out_4_i(rout_i[3]),
    .m_valid(m_valid), .m_ready(m_ready), .m_r(m_r), .m_i(m_i),
    .m_sel(m_sel), .m_last(m_last), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    nvec++;
    nbad++;
    $display("FAIL %s: cycle budget exhausted (t=%0t)", name, $time);
  endtask

  // Augmented row k = [H row k | unit vector k scaled by ONE], skewed by k steps.
  function automatic logic [W-1:0] exp_in(input int k, input int s, input bit im);
    int c;
    c = s - k;
    if (c < 0 || c >= 8) return '0;
    if (c < 4) return im ? h_i[k][c] : h_r[k][c];
    return (!im && (c - 4) == k) ? W'(ONE) : '0;
  endfunction

  // Core output for row k at step s; out-of-window values are junk.
  function automatic logic [W-1:0] core_out(input int k, input int s, input bit im);
    int rel;
    rel = s - k;
    if (rel >= 5 && rel < 9)  return im ? ri[k][rel-5] : rr[k][rel-5];
    if (rel >= 9 && rel < 13) return im ? qi[k][rel-9] : qr[k][rel-9];
    return W'($urandom);
  endfunction

  function automatic logic [W-1:0] exp_word(input int n, input bit im);
    int row, col;
    row = (n % 16) / 4;
    col = n % 4;
    if (n >= 16) return im ? qi[row][col] : qr[row][col];
    return im ? ri[row][col] : rr[row][col];
  endfunction

  task automatic chk_rst();
    chk("rst_s_ready", 32'(s_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_m_last", 32'(m_last), 0);
    chk("rst_m_sel", 32'(m_sel), 0);
    chk("rst_m_r", 32'(m_r), 0);
    chk("rst_m_i", 32'(m_i), 0);
    chk("rst_row_in_r", 32'(|rin_r), 0);
    chk("rst_row_in_i", 32'(|rin_i), 0);
    chk("rst_row_in_f", 32'(rin_f), 0);
  endtask

  // mr_mode: 0 always ready, 1 toggling 1010..., 2 random.
  task automatic session(input bit ident, input bit use_tbl, input bit gaps,
                         input int mr_mode, input bit rst9);
    int n, cyc, s;
    bit acc, rdy, ov, done, hs, mr;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        h_r[r][c] = ident ? ((r == c) ? W'(ONE) : '0) : W'($urandom);
        h_i[r][c] = ident ? '0 : W'($urandom);
        rr[r][c] = W'($urandom); ri[r][c] = W'($urandom);
        qr[r][c] = W'($urandom); qi[r][c] = W'($urandom);
      end
    end

    n = 0; cyc = 0;
    while (n < 16) begin
      if (cyc > 200) begin timeout("load"); return; end
      if (gaps && (cyc % 3 == 2)) s_valid = 1'b0;
      else begin
        s_valid = 1'b1;
        s_r = h_r[n/4][n%4];
        s_i = h_i[n/4][n%4];
      end
      chk("s_ready_load", 32'(s_ready), 1);
      acc = s_valid && s_ready;
      @(posedge clk); #1; cyc++;
      if (acc) n++;
    end
    s_valid = 1'b0;
    chk("s_ready_after16", 32'(s_ready), 0);
    chk("busy_run", 32'(busy), 1);

    s = 0; cyc = 0; done = 0;
    while (!done) begin
      if (cyc > 300) begin timeout("run"); return; end
      rdy = (use_tbl && cyc < NV) ? tbl[cyc].rdy : ($urandom_range(0, 3) != 0);
      ov  = rdy ? 1'b1 : 1'($urandom_range(0, 1));
      qrd_in_ready = rdy;
      qrd_out_valid = ov;
      for (int k = 0; k < 4; k++) begin
        rout_r[k] = core_out(k, s, 0);
        rout_i[k] = core_out(k, s, 1);
        chk($sformatf("row_in_%0d_r s=%0d", k+1, s), 32'(rin_r[k]), 32'(exp_in(k, s, 0)));
        chk($sformatf("row_in_%0d_i s=%0d", k+1, s), 32'(rin_i[k]), 32'(exp_in(k, s, 1)));
      end
      chk($sformatf("flags s=%0d", s), 32'(rin_f), {29'd0, s == 4, s == 2, s == 0});
      if (use_tbl && cyc < NV) begin
        chk($sformatf("tbl%0d_r1", cyc), 32'(rin_r[0]), tbl[cyc].r1);
        chk($sformatf("tbl%0d_r2", cyc), 32'(rin_r[1]), tbl[cyc].r2);
        chk($sformatf("tbl%0d_r3", cyc), 32'(rin_r[2]), tbl[cyc].r3);
        chk($sformatf("tbl%0d_r4", cyc), 32'(rin_r[3]), tbl[cyc].r4);
        chk($sformatf("tbl%0d_f", cyc), 32'(rin_f), 32'(tbl[cyc].f));
      end
      if (rst9 && s == 9) begin
        #2 rst = 1'b1;
        #1 chk_rst();
        #2 rst = 1'b0;
        qrd_in_ready = 1'b0;
        qrd_out_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_s_ready", 32'(s_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);
        return;
      end
      @(posedge clk); #1; cyc++;
      if (ov && s == 15) done = 1;
      else if (rdy) s++;
    end
    qrd_in_ready = 1'b0;
    qrd_out_valid = 1'b0;
    chk("drain_row_in_zero", 32'(|rin_r | |rin_i), 0);
    chk("drain_flags_zero", 32'(rin_f), 0);
    chk("drain_busy", 32'(busy), 1);
    chk("drain_s_ready", 32'(s_ready), 0);

    n = 0; cyc = 0;
    while (n < 32) begin
      if (cyc > 300) begin timeout("drain"); return; end
      mr = (mr_mode == 0) ? 1'b1 : (mr_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      m_ready = mr;
      // Inputs that must be ignored while draining.
      qrd_out_valid = 1'($urandom_range(0, 1));
      s_valid = 1'($urandom_range(0, 1));
      for (int k = 0; k < 4; k++) begin
        rout_r[k] = W'($urandom);
        rout_i[k] = W'($urandom);
      end
      if (m_valid) begin
        chk($sformatf("m_r w%0d", n), 32'(m_r), 32'(exp_word(n, 0)));
        chk($sformatf("m_i w%0d", n), 32'(m_i), 32'(exp_word(n, 1)));
        chk($sformatf("m_sel w%0d", n), 32'(m_sel), 32'(n >= 16));
        chk($sformatf("m_last w%0d", n), 32'(m_last), 32'(n == 31));
      end
      hs = m_valid && mr;
      @(posedge clk); #1; cyc++;
      if (hs) n++;
    end
    m_ready = 1'b0;
    s_valid = 1'b0;
    qrd_out_valid = 1'b0;
    chk("end_m_valid", 32'(m_valid), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_s_ready", 32'(s_ready), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Identity H: row k sees ONE at s==2k (H part) and s==2k+4 (augmented part).
    tbl[0]  = '{1'b1, 1024, 0,    0,    0,    3'b001};
    tbl[1]  = '{1'b1, 0,    0,    0,    0,    3'b000};
    tbl[2]  = '{1'b1, 0,    1024, 0,    0,    3'b010};
    tbl[3]  = '{1'b1, 0,    0,    0,    0,    3'b000};
    tbl[4]  = '{1'b1, 1024, 0,    1024, 0,    3'b100};
    tbl[5]  = '{1'b1, 0,    0,    0,    0,    3'b000};
    tbl[6]  = '{1'b0, 0,    1024, 0,    1024, 3'b000};
    tbl[7]  = '{1'b0, 0,    1024, 0,    1024, 3'b000};
    tbl[8]  = '{1'b0, 0,    1024, 0,    1024, 3'b000};
    tbl[9]  = '{1'b1, 0,    1024, 0,    1024, 3'b000};
    tbl[10] = '{1'b1, 0,    0,    0,    0,    3'b000};
    tbl[11] = '{1'b1, 0,    0,    1024, 0,    3'b000};
    tbl[12] = '{1'b1, 0,    0,    0,    0,    3'b000};
    tbl[13] = '{1'b1, 0,    0,    0,    1024, 3'b000};

    #1 rst = 1'b1;
    #1 chk_rst();
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("first_edge_s_ready", 32'(s_ready), 1);
    chk("idle_busy", 32'(busy), 0);

    session(1'b1, 1'b1, 1'b0, 0, 1'b0);
    session(1'b0, 1'b0, 1'b1, 1, 1'b0);
    session(1'b0, 1'b0, 1'b0, 2, 1'b1);
    session(1'b0, 1'b0, 1'b0, 2, 1'b0);
    session(1'b0, 1'b0, 1'b1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
